// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cache_fill_fsm
//  Description : Instruction-cache miss fill controller. On a miss it issues
//                one read per word of the missing block to pipelined main
//                memory, steers every returned word into the cache data
//                array, and writes the tag when the last word arrives.
//                fsm_busy OR'd with the raw miss forms the fetch-stage stall.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    BLOCK_WORDS       16-bit words per block (power of two, 2..16)
//    ADDR_W            byte-address width
//  Ports
//    clk               rising-edge clock
//    rst               asynchronous active-high reset
//    miss_detected     cache miss (sampled only while idle)
//    miss_address      byte address of the missing access
//    memory_data_valid main memory returns one word this cycle (in order)
//    memory_data       returned word
//    fsm_busy          fill in progress
//    memory_read       read request to main memory this cycle
//    memory_address    byte address of the current request
//    write_data_array  write fill_data into word data_word_sel
//    data_word_sel     word index within the block being written
//    fill_data         word to write (memory_data passthrough)
//    write_tag_array   one-cycle tag/valid write for the latched block
// ============================================================================
module cache_fill_fsm #(
   parameter int BLOCK_WORDS = 8,
   parameter int ADDR_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           miss_detected,
   input  logic [ADDR_W-1:0]              miss_address,
   input  logic                           memory_data_valid,
   input  logic [15:0]                    memory_data,
   output logic                           fsm_busy,
   output logic                           memory_read,
   output logic [ADDR_W-1:0]              memory_address,
   output logic                           write_data_array,
   output logic [$clog2(BLOCK_WORDS)-1:0] data_word_sel,
   output logic [15:0]                    fill_data,
   output logic                           write_tag_array
);

   localparam int SEL_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W = SEL_W + 1;
   localparam int OFF   = SEL_W + 1;

   // Clears the byte-offset bits to get the block-aligned base address.
   localparam logic [ADDR_W-1:0] c_BASE_MASK  = {ADDR_W{1'b1}} << OFF;
   localparam logic [CNT_W-1:0]  c_REQ_DONE   = CNT_W'(BLOCK_WORDS);
   localparam logic [SEL_W-1:0]  c_LAST_WORD  = SEL_W'(BLOCK_WORDS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   state_t              state_q,   state_d;
   logic [ADDR_W-1:0]   base_q,    base_d;
   logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
   logic [SEL_W-1:0]    rsp_cnt_q, rsp_cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         req_cnt_q <= '0;
         rsp_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         req_cnt_q <= req_cnt_d;
         rsp_cnt_q <= rsp_cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      req_cnt_d        = req_cnt_q;
      rsp_cnt_d        = rsp_cnt_q;
      fsm_busy         = 1'b0;
      memory_read      = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      data_word_sel    = '0;
      fill_data        = '0;
      write_tag_array  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Returning words are ignored here, which also discards any
            // responses still in flight from a fill aborted by reset.
            if (miss_detected) begin
               base_d    = miss_address & c_BASE_MASK;
               req_cnt_d = '0;
               rsp_cnt_d = '0;
               state_d   = ST_FILL;
            end
         end

         ST_FILL: begin
            fsm_busy = 1'b1;

            // Request side: one read per cycle until the block is covered.
            if (req_cnt_q < c_REQ_DONE) begin
               memory_read    = 1'b1;
               memory_address = base_q + ADDR_W'({req_cnt_q, 1'b0});
               req_cnt_d      = req_cnt_q + 1'b1;
            end

            // Response side runs independently of the request side; the
            // last word and the tag write always land in the same cycle.
            if (memory_data_valid) begin
               write_data_array = 1'b1;
               data_word_sel    = rsp_cnt_q;
               fill_data        = memory_data;
               rsp_cnt_d        = rsp_cnt_q + 1'b1;
               if (rsp_cnt_q == c_LAST_WORD) begin
                  write_tag_array = 1'b1;
                  state_d         = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_fsm
//  Description : Self-checking bench for cache_fill_fsm (BLOCK_WORDS=8,
//                ADDR_W=16). A cycle-indexed reference model predicts every
//                output each cycle; directed fills are logged and a set of
//                literal expectations pins the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

   localparam int BW = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = '0;
   logic        memory_data_valid = 1'b0;
   logic [15:0] memory_data = '0;
   logic        fsm_busy;
   logic        memory_read;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  data_word_sel;
   logic [15:0] fill_data;
   logic        write_tag_array;

   int checks   = 0;
   int failures = 0;

   cache_fill_fsm #(.BLOCK_WORDS(BW), .ADDR_W(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .fsm_busy          (fsm_busy),
      .memory_read       (memory_read),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .data_word_sel     (data_word_sel),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: a fill is described by its start edge and base.
   // Requests are a pure function of how many edges have passed since
   // the start; responses are numbered by how many valids were accepted.
   // ------------------------------------------------------------------
   int          edge_no = 0;
   bit          m_active = 0;
   int          m_start = 0;
   int          m_words_back = 0;
   logic [15:0] m_base = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active     <= 0;
         m_words_back <= 0;
         m_base       <= '0;
      end else begin
         edge_no <= edge_no + 1;
         if (!m_active) begin
            if (miss_detected) begin
               m_active     <= 1;
               m_start      <= edge_no + 1;
               m_base       <= {miss_address[15:4], 4'h0};
               m_words_back <= 0;
            end
         end else if (memory_data_valid) begin
            m_words_back <= m_words_back + 1;
            if (m_words_back + 1 == BW) m_active <= 0;
         end
      end
   end

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      int          k;
      logic        e_rd, e_wr, e_tag;
      logic [15:0] e_addr, e_data;
      logic [2:0]  e_sel;
      k      = edge_no - m_start;   // requests issued before this cycle
      e_rd   = m_active && (k >= 0) && (k < BW);
      e_addr = e_rd ? m_base + 16'(2 * k) : 16'h0;
      e_wr   = m_active && memory_data_valid;
      e_sel  = e_wr ? 3'(m_words_back) : 3'd0;
      e_data = e_wr ? memory_data : 16'h0;
      e_tag  = e_wr && (m_words_back == BW - 1);
      cmp("busy",  {15'd0, fsm_busy},         {15'd0, m_active});
      cmp("read",  {15'd0, memory_read},      {15'd0, e_rd});
      cmp("addr",  memory_address,            e_addr);
      cmp("wr",    {15'd0, write_data_array}, {15'd0, e_wr});
      cmp("sel",   {13'd0, data_word_sel},    {13'd0, e_sel});
      cmp("data",  fill_data,                 e_data);
      cmp("tag",   {15'd0, write_tag_array},  {15'd0, e_tag});
   end

   // ------------------------------------------------------------------
   // Directed fill driver. Cycle 1 is the cycle after the edge that
   // samples the miss. Outputs are logged per cycle for literal checks.
   // ------------------------------------------------------------------
   logic        lg_busy [0:63];
   logic        lg_rd   [0:63];
   logic [15:0] lg_addr [0:63];
   logic        lg_wr   [0:63];
   logic [2:0]  lg_sel  [0:63];
   logic        lg_tag  [0:63];

   task automatic run_fill(input logic [15:0] addr, input logic [63:0] vmask,
                           input int ncyc, input bit hold_miss,
                           input logic [15:0] addr2, input int addr2_cyc,
                           input int rst_cyc);
      miss_detected     = 1'b1;
      miss_address      = addr;
      memory_data_valid = 1'b0;
      @(posedge clk); #1;
      for (int c = 1; c <= ncyc; c++) begin
         miss_detected     = hold_miss ? 1'b1 : (c < 3);
         if (c == addr2_cyc) miss_address = addr2;
         memory_data_valid = vmask[c];
         memory_data       = 16'($urandom);
         rst               = (c == rst_cyc);
         @(negedge clk);
         lg_busy[c] = fsm_busy;
         lg_rd[c]   = memory_read;
         lg_addr[c] = memory_address;
         lg_wr[c]   = write_data_array;
         lg_sel[c]  = data_word_sel;
         lg_tag[c]  = write_tag_array;
         @(posedge clk); #1;
      end
      rst               = 1'b0;
      miss_detected     = 1'b0;
      memory_data_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] vrange(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   initial begin
      int n;
      logic [63:0] vm;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      cmp("rst_busy", {15'd0, fsm_busy}, 16'd0);
      cmp("rst_read", {15'd0, memory_read}, 16'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic fill, latency 4
      run_fill(16'h1236, vrange(5, 12), 14, 0, 16'h1236, 0, 0);
      cmp("basic_addr_c1", lg_addr[1], 16'h1230);
      cmp("basic_addr_c8", lg_addr[8], 16'h123E);
      cmp("basic_rd_c9",   {15'd0, lg_rd[9]}, 16'd0);
      cmp("basic_wr_c4",   {15'd0, lg_wr[4]}, 16'd0);
      cmp("basic_sel_c12", {13'd0, lg_sel[12]}, 16'd7);
      cmp("basic_tag_c11", {15'd0, lg_tag[11]}, 16'd0);
      cmp("basic_tag_c12", {15'd0, lg_tag[12]}, 16'd1);
      cmp("basic_busy_c12", {15'd0, lg_busy[12]}, 16'd1);
      cmp("basic_busy_c13", {15'd0, lg_busy[13]}, 16'd0);

      // Top-of-memory block, no wrap
      run_fill(16'hFFFB, vrange(5, 12), 13, 0, 16'hFFFB, 0, 0);
      cmp("top_addr_c1", lg_addr[1], 16'hFFF0);
      cmp("top_addr_c8", lg_addr[8], 16'hFFFE);
      cmp("top_tag_c12", {15'd0, lg_tag[12]}, 16'd1);

      // Miss dropped and address changed mid-fill
      run_fill(16'h1236, vrange(5, 12), 13, 0, 16'h4000, 3, 0);
      cmp("mid_addr_c4", lg_addr[4], 16'h1236);
      cmp("mid_addr_c8", lg_addr[8], 16'h123E);

      // Stray valids while idle
      for (int i = 0; i < 4; i++) begin
         memory_data_valid = 1'b1;
         memory_data       = 16'hBEEF;
         @(negedge clk);
         cmp("stray_wr", {15'd0, write_data_array}, 16'd0);
         @(posedge clk); #1;
      end
      memory_data_valid = 1'b0;

      // Irregular returns
      vm = '0;
      vm[5] = 1; vm[7] = 1; vm[8] = 1; vm[12] = 1;
      vm[13] = 1; vm[14] = 1; vm[20] = 1; vm[21] = 1;
      run_fill(16'h0A10, vm, 23, 0, 16'h0A10, 0, 0);
      cmp("irr_sel_c14", {13'd0, lg_sel[14]}, 16'd5);
      cmp("irr_wr_c15",  {15'd0, lg_wr[15]}, 16'd0);
      cmp("irr_tag_c20", {15'd0, lg_tag[20]}, 16'd0);
      cmp("irr_tag_c21", {15'd0, lg_tag[21]}, 16'd1);
      cmp("irr_busy_c21", {15'd0, lg_busy[21]}, 16'd1);
      cmp("irr_busy_c22", {15'd0, lg_busy[22]}, 16'd0);

      // Reset mid-fill, responses keep arriving afterwards
      run_fill(16'h3456, vrange(5, 12), 13, 0, 16'h3456, 0, 6);
      cmp("rst_wr_c5",   {15'd0, lg_wr[5]}, 16'd1);
      cmp("rst_busy_c6", {15'd0, lg_busy[6]}, 16'd0);
      cmp("rst_rd_c6",   {15'd0, lg_rd[6]}, 16'd0);
      n = 0;
      for (int c = 6; c <= 13; c++) n += int'(lg_wr[c]) + int'(lg_tag[c]);
      cmp("rst_no_writes", 16'(n), 16'd0);
      run_fill(16'h1236, vrange(5, 12), 13, 0, 16'h1236, 0, 0);
      cmp("restart_wr_c5",  {15'd0, lg_wr[5]}, 16'd1);
      cmp("restart_sel_c5", {13'd0, lg_sel[5]}, 16'd0);
      cmp("restart_tag_c12", {15'd0, lg_tag[12]}, 16'd1);

      // Back-to-back misses: second fill starts after one idle cycle
      run_fill(16'h1236, vrange(5, 12) | vrange(18, 25), 26, 1, 16'h2002, 13, 0);
      cmp("b2b_idle_c13", {15'd0, lg_busy[13]}, 16'd0);
      cmp("b2b_addr_c14", lg_addr[14], 16'h2000);
      cmp("b2b_addr_c21", lg_addr[21], 16'h200E);
      n = 0;
      for (int c = 1; c <= 13; c++) n += int'(lg_rd[c]);
      cmp("b2b_reqs_fill1", 16'(n), 16'd8);
      n = 0;
      for (int c = 14; c <= 26; c++) n += int'(lg_rd[c]);
      cmp("b2b_reqs_fill2", 16'(n), 16'd8);
      cmp("b2b_tag_c25", {15'd0, lg_tag[25]}, 16'd1);

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that sits between the instruction-fetch stage's cache arrays and the multi-cycle main memory. On a cache miss it:
- issues one read per word of the missing block to pipelined main memory;
- steers each returned word into the cache data array;
- writes the tag once the whole block has arrived.

Its busy output, OR'd with the raw miss, is the fetch-stage stall.

## Interface
- BLOCK_WORDS, 8, 16-bit words per cache block; power of two, 2..16
- ADDR_W, 16, byte-address width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- miss_detected  in  1  level, cache miss on the current access; sampled only in IDLE
- miss_address  in  ADDR_W  byte address of the missing access; latched when a fill starts
- memory_data_valid  in  1  main memory returns one word this cycle (in request order)
- memory_data  in  16  returned word
- fsm_busy  out  1  fill in progress
- memory_read  out  1  read request to main memory this cycle
- memory_address  out  ADDR_W  byte address of the current request
- write_data_array  out  1  write fill_data into data array word data_word_sel
- data_word_sel  out  log2(BLOCK_WORDS)  word index within block being written
- fill_data  out  16  word to write (equals memory_data)
- write_tag_array  out  1  one-cycle tag/valid write for the latched block

## Operation
- Block geometry:
  - OFF = log2(BLOCK_WORDS)+1 byte-offset bits.
  - base = miss_address with bits [OFF-1:0] cleared, latched at fill start.
- There are two states, IDLE and FILL.
- Registers: state, base, req_cnt (0..BLOCK_WORDS), rsp_cnt (0..BLOCK_WORDS-1).
- IDLE:
  - All outputs are 0.
  - If miss_detected=1 at the clock edge: latch base, clear req_cnt and rsp_cnt, go to FILL.
  - memory_data_valid is ignored.
- FILL, request side:
  - While req_cnt < BLOCK_WORDS: memory_read=1 and memory_address = base + 2*req_cnt; req_cnt increments every cycle.
  - One request is issued per cycle with no backpressure.
  - Once req_cnt = BLOCK_WORDS, memory_read=0 and memory_address=0.
- FILL, response side (combinational on memory_data_valid):
  - write_data_array=1, data_word_sel=rsp_cnt, fill_data=memory_data; rsp_cnt increments.
  - When valid arrives with rsp_cnt = BLOCK_WORDS-1: write_tag_array=1 in the same cycle, and the next state is IDLE.
- Requests and responses may overlap in the same cycle. The two counters are independent.
- fsm_busy = (state==FILL).
- Once a fill starts it runs to completion. Deasserting miss_detected or changing miss_address mid-fill has no effect.
- Address arithmetic is ADDR_W-bit. The block never crosses its aligned boundary, so it never wraps; e.g. base 0xFFF0 gives 0xFFF0..0xFFFE.

## Timing
- Reset (asynchronous, any time, including mid-fill):
  - state=IDLE, counters=0, base=0, all outputs 0 immediately.
  - No tag write occurs for an aborted fill.
  - Responses still in flight after reset are ignored, because they arrive while the block is in IDLE.
- Start: edge E0 samples the miss. fsm_busy and the first memory_read are high in cycle 1 (after E0).
- Requests occupy cycles 1..BLOCK_WORDS.
- Memory latency L (request in cycle n, valid in cycle n+L):
  - Data writes occur in cycles 1+L .. BLOCK_WORDS+L.
  - write_tag_array is high in cycle BLOCK_WORDS+L.
  - fsm_busy drops in cycle BLOCK_WORDS+L+1.
- Back-to-back miss: if miss_detected is still high in the first IDLE cycle, a new fill starts at that edge. There is one idle cycle between fills.
- write_tag_array and the final write_data_array are never both absent in the completing cycle; they always coincide.

## Test plan
- Basic fill, L=4, BLOCK_WORDS=8:
  - Stimulus: miss at 0x1236.
  - Requests 0x1230,0x1232,…,0x123E in cycles 1–8.
  - Writes sel 0..7 in cycles 5–12 with data echoed.
  - write_tag_array only in cycle 12; fsm_busy high in cycles 1–12.
- Top-of-memory block: miss at 0xFFFB → addresses 0xFFF0..0xFFFE, no wrap, tag write after 8th response.
- Mid-fill changes and stray valids:
  - miss_detected dropped and miss_address changed to 0x4000 in cycle 3 → remaining requests stay in block 0x1230.
  - Stray memory_data_valid pulses in IDLE → no write_data_array.
- Irregular returns: responses with gaps (valid in cycles 5,7,8,12,13,14,20,21) → data_word_sel 0..7 in order, tag write in cycle 21, busy low in cycle 22.
- Reset mid-fill: rst asserted in cycle 6 → all outputs 0 immediately, never write_tag_array, remaining responses ignored, next miss restarts at word 0.
- Back-to-back misses: miss held high → second fill begins the cycle after busy drops with a new base; request count is exactly 8 per fill.
